// File: rtl/sseg_pkg.sv
// sseg_pkg: shared seven-segment pattern constants and anode helpers for the capture path
package sseg_pkg;
    localparam logic [6:0] SSEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] SSEG_MINUS = 7'b0111111;
    localparam logic [6:0] SSEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_NONE    = 4'b1111;

    // Digit index of an active-low one-hot anode code; only meaningful for legal codes.
    function automatic logic [1:0] an_index(input logic [3:0] an);
        return an == 4'b1110 ? 2'd0 : an == 4'b1101 ? 2'd1 : an == 4'b1011 ? 2'd2 : 2'd3;
    endfunction
endpackage

// File: rtl/sseg_pattern_decoder.sv
// sseg_pattern_decoder: maps an active-low segment pattern back to a hex nibble
// Ports: i_seg pattern in; o_nibble decoded value, o_is_minus for the minus glyph,
//        o_known when i_seg matches one of the sixteen hex glyphs.
module sseg_pattern_decoder
    import sseg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_is_minus,
    output logic       o_known
);
    always_comb begin
        o_nibble = 4'h0;
        o_known  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == SSEG_HEX[i]) begin
                o_nibble = 4'(i);
                o_known  = 1'b1;
            end
        end
    end

    assign o_is_minus = i_seg == SSEG_MINUS;
endmodule

// File: rtl/sseg4_capture.sv
// sseg4_capture: rebuilds a four-digit value and sign from a multiplexed seven-segment pin bus
// Ports: clock, reset (async, active-low); seg/dp/an display pins in;
//        data/sign last complete frame, frame_valid strobe on update,
//        err strobe on bad anode code or unknown glyph, stale while no digit has been captured recently.
module sseg4_capture
    import sseg_pkg::*;
#(
    parameter int SETTLE    = 4,
    parameter int TIMEOUT_W = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic        dp,
    input  logic [3:0]  an,
    output logic [15:0] data,
    output logic        sign,
    output logic        frame_valid,
    output logic        err,
    output logic        stale
);
    localparam int CW = $clog2(SETTLE);

    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [10:0]          r_prev;
    logic [CW-1:0]        r_cnt;
    logic [15:0]          r_shadow;
    logic                 r_sign_sh;
    logic [3:0]           r_mask;
    logic [TIMEOUT_W-1:0] r_wd;

    logic [3:0] w_nibble;
    logic [3:0] w_sel;
    logic [1:0] w_idx;
    logic       w_is_minus;
    logic       w_known;
    logic       w_same;
    logic       w_sample;
    logic       w_blank;
    logic       w_onehot;
    logic       w_minus_ok;
    logic       w_capture;
    logic       w_bad;
    logic       w_full;
    logic       w_expire;
    logic       w_unused;

    sseg_pattern_decoder u_dec (
        .i_seg      (r_seg),
        .o_nibble   (w_nibble),
        .o_is_minus (w_is_minus),
        .o_known    (w_known)
    );

    // dp is captured with the bus but carries nothing that is decoded
    assign w_unused   = r_dp;
    assign w_sel      = ~r_an;
    assign w_idx      = an_index(r_an);
    assign w_same     = {r_an, r_seg} == r_prev;
    // r_cnt counts equal consecutive pairs, so SETTLE identical registered values
    // are seen when an equal pair arrives with SETTLE-2 already counted
    assign w_sample   = w_same && r_cnt == CW'(SETTLE - 2);
    assign w_blank    = r_an == AN_NONE;
    assign w_onehot   = w_sel != 4'h0 && (w_sel & (w_sel - 4'h1)) == 4'h0;
    assign w_minus_ok = w_is_minus && w_idx == 2'd3;
    assign w_capture  = w_sample && w_onehot && (w_known || w_minus_ok);
    assign w_bad      = w_sample && !w_blank && !(w_onehot && (w_known || w_minus_ok));
    assign w_full     = r_mask == 4'hF;
    // a capture on the expiry edge wins over the watchdog
    assign w_expire   = !w_capture && &r_wd;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_an        <= AN_NONE;
            r_seg       <= SSEG_BLANK;
            r_dp        <= 1'b1;
            r_prev      <= {AN_NONE, SSEG_BLANK};
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_sign_sh   <= 1'b0;
            r_mask      <= 4'h0;
            r_wd        <= '0;
            data        <= 16'h0000;
            sign        <= 1'b0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            stale       <= 1'b0;
        end else begin
            r_an        <= an;
            r_seg       <= seg;
            r_dp        <= dp;
            r_prev      <= {r_an, r_seg};
            r_cnt       <= !w_same ? '0 : (r_cnt == CW'(SETTLE - 1) ? r_cnt : r_cnt + 1'b1);
            frame_valid <= w_full;
            err         <= w_bad;
            if (w_full) begin
                data <= r_shadow;
                sign <= r_sign_sh;
            end
            if (w_capture) begin
                r_shadow[{w_idx, 2'b00} +: 4] <= w_minus_ok ? 4'h0 : w_nibble;
                if (w_idx == 2'd3)
                    r_sign_sh <= w_minus_ok;
            end
            r_mask <= (w_full || w_expire) ? 4'h0 : (w_capture ? r_mask | w_sel : r_mask);
            r_wd   <= w_capture ? '0 : (&r_wd ? r_wd : r_wd + 1'b1);
            stale  <= w_capture ? 1'b0 : (w_expire ? 1'b1 : stale);
        end
    end
endmodule

// File: tb/tb_sseg4_capture.sv
// tb_sseg4_capture: randomized and directed checks of sseg4_capture against a behavioural model
module tb_sseg4_capture;
    localparam int SETTLE = 4;
    localparam int TW     = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic        dp = 1'b1;
    logic [3:0]  an = 4'hF;
    logic [15:0] data;
    logic        sign;
    logic        frame_valid;
    logic        err;
    logic        stale;

    int errors = 0;
    int checks = 0;
    int n_fv = 0;
    int n_err = 0;
    int f0, e0;
    time t_d3 = 0;
    time t_fv = 0;

    // behavioural model state
    logic [15:0] m_data = 0;
    bit          m_sign = 0, m_fv = 0, m_err = 0, m_stale = 0, m_sgn_sh = 0, m_pend = 0, m_cap = 0;
    bit   [3:0]  m_have = 0;
    int          m_dig [4] = '{0, 0, 0, 0};
    int          m_since = 0, m_run = 1, m_zeros = 0, m_k = 0;
    logic [10:0] m_last = 11'h7FF, m_pv = 11'h7FF;

    sseg4_capture #(.SETTLE(SETTLE), .TIMEOUT_W(TW)) dut (
        .clock       (clk),
        .reset       (rst_n),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .data        (data),
        .sign        (sign),
        .frame_valid (frame_valid),
        .err         (err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hexpat(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input logic [15:0] v, input bit minus, input int lo, input int hi, input int dwell);
        for (int k = lo; k <= hi; k++) begin
            if (k == 3) t_d3 = $time;
            drive(4'(~(4'b0001 << k)), (k == 3 && minus) ? 7'b0111111 : hexpat(v[4*k +: 4]), dwell);
        end
    endtask

    task automatic blank(input int n);
        drive(4'hF, 7'h7F, n);
    endtask

    // Model: a registered pin value held for SETTLE cycles is classified on the
    // following edge; a full set of digits publishes one edge later; the watchdog
    // trips once 2^TW edges pass without a capture.
    task automatic model_step();
        if (!rst_n) begin
            m_data = 0; m_sign = 0; m_fv = 0; m_err = 0; m_stale = 0; m_sgn_sh = 0;
            m_have = 0; m_dig = '{0, 0, 0, 0}; m_since = 0; m_pend = 0;
            m_last = 11'h7FF; m_run = 1;
            return;
        end
        m_fv = m_have == 4'hF;
        if (m_fv) begin
            m_data = 16'(m_dig[3] * 4096 + m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0]);
            m_sign = m_sgn_sh;
            m_have = 0;
        end
        m_err = 0;
        m_cap = 0;
        if (m_pend) begin
            m_zeros = 0;
            for (int j = 0; j < 4; j++) if (!m_pv[7+j]) begin m_zeros++; m_k = j; end
            if (m_zeros == 1) begin
                if (m_k == 3 && m_pv[6:0] == 7'b0111111) begin
                    m_dig[3] = 0; m_sgn_sh = 1; m_have[3] = 1; m_cap = 1;
                end else begin
                    for (int n = 0; n < 16; n++) if (hexpat(4'(n)) == m_pv[6:0]) begin
                        m_dig[m_k] = n; m_have[m_k] = 1; m_cap = 1;
                        if (m_k == 3) m_sgn_sh = 0;
                    end
                end
                if (!m_cap) m_err = 1;
            end else if (m_zeros != 0) m_err = 1;
        end
        if (m_cap) begin
            m_since = 0; m_stale = 0;
        end else begin
            m_since++;
            if (m_since >= (1 << TW)) begin m_stale = 1; m_have = 0; end
        end
        if ({an, seg} == m_last) m_run++; else m_run = 1;
        m_last = {an, seg};
        m_pv   = m_last;
        m_pend = m_run == SETTLE;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        checks++;
        if ({data, sign, frame_valid, err, stale} !== {m_data, m_sign, m_fv, m_err, m_stale}) begin
            errors++;
            $display("FAIL model_compare t=%0t data=%h/%h sign=%b/%b fv=%b/%b err=%b/%b stale=%b/%b (dut/model)",
                     $time, data, m_data, sign, m_sign, frame_valid, m_fv, err, m_err, stale, m_stale);
        end
        if (frame_valid === 1'b1) begin n_fv++; t_fv = $time; end
        if (err === 1'b1) n_err++;
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data), 0);
        check("reset_flags", {sign, frame_valid, err, stale}, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        f0 = n_fv; e0 = n_err;
        show(16'h1A2F, 0, 0, 3, 20); blank(10); #1;
        check("hex_fv_count", n_fv - f0, 1);
        check("hex_data", 32'(data), 32'h1A2F);
        check("hex_sign", 32'(sign), 0);
        check("hex_no_err", n_err - e0, 0);
        check("hex_latency", 32'(t_fv - t_d3), 60);

        f0 = n_fv;
        show(16'h0123, 1, 0, 3, 20); blank(10); #1;
        check("minus_fv_count", n_fv - f0, 1);
        check("minus_data", 32'(data), 32'h0123);
        check("minus_sign", 32'(sign), 1);

        f0 = n_fv; e0 = n_err;
        drive(4'b1110, hexpat(5), 20);
        drive(4'b1101, hexpat(5), 8);
        drive(4'b1101, 7'b0000000, 2);
        drive(4'b1101, hexpat(5), 10);
        show(16'h5555, 0, 2, 3, 20); blank(10); #1;
        check("glitch_data", 32'(data), 32'h5555);
        check("glitch_sign", 32'(sign), 0);
        check("glitch_no_err", n_err - e0, 0);
        check("glitch_fv_count", n_fv - f0, 1);

        f0 = n_fv; e0 = n_err;
        show(16'hBEEF, 0, 0, 1, 20);
        drive(4'b1100, hexpat(3), 10);
        show(16'hBEEF, 0, 2, 3, 20); blank(10); #1;
        check("badan_err_count", n_err - e0, 1);
        check("badan_fv_count", n_fv - f0, 1);
        check("badan_data", 32'(data), 32'hBEEF);

        f0 = n_fv;
        show(16'h9876, 0, 0, 2, 20); blank(80); #1;
        check("wd_stale_set", 32'(stale), 1);
        drive(4'b0111, hexpat(9), 20); #1;
        check("wd_stale_clear", 32'(stale), 0);
        check("wd_no_partial_fv", n_fv - f0, 0);
        show(16'h9543, 0, 0, 2, 20); blank(10); #1;
        check("wd_new_frame_fv", n_fv - f0, 1);
        check("wd_new_frame_data", 32'(data), 32'h9543);

        show(16'h4321, 0, 0, 2, 20);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_data", 32'(data), 0);
        check("rst_mid_flags", {sign, frame_valid, err, stale}, 0);
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b1;
        f0 = n_fv;
        drive(4'b0111, hexpat(4), 20); blank(10); #1;
        check("rst_no_stale_fv", n_fv - f0, 0);
        show(16'h4321, 0, 0, 2, 20); blank(10); #1;
        check("rst_fresh_fv", n_fv - f0, 1);
        check("rst_fresh_data", 32'(data), 32'h4321);

        for (int i = 0; i < 300; i++) begin
            int sel, k, dw;
            logic [3:0] a;
            logic [6:0] s;
            sel = $urandom_range(0, 9);
            k   = $urandom_range(0, 3);
            a   = 4'(~(4'b0001 << k));
            s   = hexpat(4'($urandom_range(0, 15)));
            dw  = $urandom_range(SETTLE, 12);
            if (sel == 0) s = 7'($urandom);
            else if (sel == 1) a = 4'($urandom);
            else if (sel == 2) dw = $urandom_range(1, SETTLE - 1);
            else if (sel == 3) begin a = 4'hF; dw = $urandom_range(1, 90); end
            else if (sel == 4 && k == 3) s = 7'b0111111;
            dp = 1'($urandom);
            drive(a, s, dw);
        end
        blank(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
